// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit adder/subtractor: one 4-bit carry-lookahead group per stage,
// with skew registers carrying pending operand bits and finished sum bits along.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGRP = WIDTH / 4;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipe moves as one; a stalled final stage freezes every stage.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    // Returns {c4, s[3:0]} for one 4-bit lookahead group.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        logic           vin;
        logic [3:0]     ga;
        logic [3:0]     gb;
        logic           gc;
        logic [4:0]     r;
        logic [4*k+3:0] sum_nxt;
        logic           vld;
        logic           cq;
        logic [4*k+3:0] sum_q;

        if (k == 0) begin : g_in
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            assign a_src   = a;
            assign b_src   = b_eff;
            assign vin     = in_valid;
            assign gc      = c0;
            assign sum_nxt = r[3:0];
        end else begin : g_in
            logic [WIDTH-1:4*k] a_src;
            logic [WIDTH-1:4*k] b_src;
            assign a_src   = g_stage[k-1].g_fwd.a_hi;
            assign b_src   = g_stage[k-1].g_fwd.b_hi;
            assign vin     = g_stage[k-1].vld;
            assign gc      = g_stage[k-1].cq;
            assign sum_nxt = {r[3:0], g_stage[k-1].sum_q};
        end

        assign ga = g_in.a_src[4*k+3:4*k];
        assign gb = g_in.b_src[4*k+3:4*k];
        assign r  = cla4(ga, gb, gc);

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value; data registers are reset
        // too, so outputs read as zero while the pipe is empty after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld   <= 1'b0;
                cq    <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                vld   <= vin;
                cq    <= r[4];
                sum_q <= sum_nxt;
            end
        end

        if (k < NGRP - 1) begin : g_fwd
            logic [WIDTH-1:4*k+4] a_hi;
            logic [WIDTH-1:4*k+4] b_hi;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (en) begin
                    a_hi <= g_in.a_src[WIDTH-1:4*k+4];
                    b_hi <= g_in.b_src[WIDTH-1:4*k+4];
                end
            end
        end

        if (k == NGRP - 1) begin : g_last
            logic c3q;
            // Carry into the MSB recovered from the sum bit: s3 = p3 ^ c3.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c3q <= 1'b0;
                end else if (en) begin
                    c3q <= r[3] ^ ga[3] ^ gb[3];
                end
            end
        end
    end

    assign out_valid = g_stage[NGRP-1].vld;
    assign sum       = g_stage[NGRP-1].sum_q;
    assign cout      = g_stage[NGRP-1].cq;
    assign ovf       = g_stage[NGRP-1].g_last.c3q ^ g_stage[NGRP-1].cq;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16): vector table, latency,
// random backpressure and reset-in-flight sequences against a scoreboard queue.
module tb_pipelined_cla_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];
    res_t cur_exp;
    res_t e_pop;
    res_t prev_out;
    logic prev_stall = 1'b0;
    bit   rand_ready = 1'b0;
    vec_t vecs[9];

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   full;
        res_t         rr;
        yy      = s ? ~y : y;
        full    = {1'b0, x} + {1'b0, yy} + (W+1)'(s ? 1'b1 : c);
        rr.sum  = full[W-1:0];
        rr.cout = full[W];
        rr.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return rr;
    endfunction

    // Downstream ready: random during the backpressure phase, otherwise always 1.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor and scoreboard, sampled mid-cycle: inputs and out_ready are stable here.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", {sum, cout, ovf}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got sum=%0h with empty scoreboard at %0t",
                             sum, $time);
                end else begin
                    e_pop = sb.pop_front();
                    check("result{sum,cout,ovf}", {sum, cout, ovf}, e_pop);
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            prev_stall = out_valid && !out_ready;
            prev_out   = {sum, cout, ovf};
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        cur_exp  = v.exp;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check("drain_empty", 64'(sb.size()), 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);
    endtask

    // Single op into an empty pipe: out_valid must rise after exactly 4 edges.
    task automatic latency_op(input vec_t v);
        @(posedge clk);
        #1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        cur_exp  = v.exp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("latency_edge%0d", i + 1), out_valid, (i == 3) ? 1 : 0);
        end
    endtask

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0}};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};

        #12;
        rst_n = 1'b1;
        apply_reset();

        latency_op(vecs[0]);
        drain();

        for (int i = 0; i < 9; i++) send(vecs[i]);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.cin = 1'($urandom_range(0, 1));
            v.sub = 1'($urandom_range(0, 1));
            v.exp = model(v.a, v.b, v.cin, v.sub);
            send(v);
        end
        rand_ready = 1'b0;
        drain();

        for (int i = 0; i < 3; i++) send(vecs[i + 5]);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_output_after_flush", out_valid, 0);
        end
        latency_op(vecs[4]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
